shift_sequencer: RTL

Sequencing controller for the register-file shift datapath. It accepts one shift command per handshake: read source register, left-shift by N, write destination register. It drives the synchronous-read register file and the registered 16-bit left shifter, each with one cycle of latency, so software-level commands execute as fixed 4-cycle transactions. It sits between the lab top-level command source (switch/FSM driver) and the register file plus shifter pair.

---
 rtl/shift_sequencer_pkg.sv | 17 +
 rtl/shift_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the register-file shift sequencer: widths, FSM encoding
// and the shift-amount saturation threshold.
package shift_sequencer_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned SHAMT_SAT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SH   = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Sequences one read / left-shift / write-back command through a synchronous-read
// register file and a registered shifter as a fixed 4-cycle transaction.
module shift_sequencer #(
  parameter int unsigned DATA_W  = shift_sequencer_pkg::DATA_W,
  parameter int unsigned ADDR_W  = shift_sequencer_pkg::ADDR_W,
  parameter int unsigned SHAMT_W = shift_sequencer_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_src,
  input  logic [ADDR_W-1:0]  cmd_dst,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [ADDR_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  sh_a,
  output logic [3:0]         sh_shift,
  input  logic [DATA_W-1:0]  sh_r,
  output logic               busy,
  output logic               done,
  output logic [7:0]         done_cnt
);
  import shift_sequencer_pkg::*;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    src_q, dst_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [7:0]           cnt_q;
  logic                 accept;
  logic                 sat;

  assign accept = (state == IDLE) && cmd_valid;
  assign sat    = (shamt_q >= SHAMT_W'(SHAMT_SAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_q   <= cmd_src;
        dst_q   <= cmd_dst;
        shamt_q <= cmd_shamt;
      end
      if (state == WB) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RD;
      RD:      state_nxt = SH;
      SH:      state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every strobe and datapath output is forced low while rst is held, so a WB
  // cycle coinciding with reset never writes.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rf_we     = 1'b0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    sh_a      = '0;
    sh_shift  = '0;
    if (!rst) begin
      rf_raddr = src_q;
      case (state)
        IDLE: cmd_ready = 1'b1;
        RD:   busy = 1'b1;
        SH: begin
          busy = 1'b1;
          if (!sat) begin
            sh_a     = rf_rdata;
            sh_shift = shamt_q[3:0];
          end
        end
        WB: begin
          busy     = 1'b1;
          done     = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = dst_q;
          rf_wdata = sh_r;
        end
        default: ;
      endcase
    end
  end

  assign done_cnt = cnt_q;

endmodule
